mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU datapath's MAR/MDR memory port. Serves one word read or write per request through a req/ack handshake, with a parameterised number of wait states. It replaces the zero-latency RAM so the control unit can be exercised against slow memory. Storage is an internal 32-bit word array addressed by the 9-bit MAR value.

## Interface
- DEPTH, 512 — number of 32-bit words; legal addresses are 0..DEPTH-1; DEPTH ≤ 512.
- WAIT_CYCLES, 2 — wait states inserted before ack; range 0..15.
- Clock  input  1  — single clock; all state updates on the rising edge.
- Reset_n  input  1  — asynchronous, active-low reset.
- req  input  1  — request strobe from the control unit.
- we  input  1  — 1 = write, 0 = read; sampled with req.
- addr  input  9  — word address (MAR output).
- wdata  input  32  — write data (MDR output).
- rdata  output  32  — read data to MDR Mdatain.
- ack  output  1  — one-cycle completion pulse.
- busy  output  1  — high from capture until the ack cycle, inclusive.
- err  output  1  — out-of-range flag, valid with ack (see Configuration).

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: when req=1 at a rising edge, latch we/addr/wdata and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else to ACK.
- WAIT: the counter decrements each edge. The access executes on the edge where the counter moves from 1 to 0, and the FSM enters ACK on that same edge.
- Access:
  - Write: mem[addr_q] <= wdata_q; rdata is unchanged.
  - Read: rdata <= mem[addr_q].
- ACK: ack=1 for exactly one cycle, then unconditionally IDLE.
- req, we, addr and wdata are ignored outside IDLE. A req still high in the IDLE cycle after ACK is captured as a new request, so the requester drops req on seeing ack.
- rdata holds the last read value until the next read completes.
- Reset (any time):
  - State, outputs and registers: state=IDLE, ack=0, busy=0, err=0, rdata=0, counter=0.
  - Pending transaction: an access not yet executed is discarded, and no memory write occurs.
  - Memory array: contents are not reset.

## Timing
- Capture edge E0, with req=1 in IDLE.
- Access edge: E0+WAIT_CYCLES. With WAIT_CYCLES=0 the access executes at E0 on the latched values.
- ack is high in the cycle after E0+WAIT_CYCLES; the capture-to-ack latency is WAIT_CYCLES+1 edges.
- busy rises after E0 and falls after the ack cycle.
- Minimum request-to-request period is WAIT_CYCLES+2 cycles.
- A write followed by a read of the same address returns the new data.

## Configuration
- MEM_RESPONDER_RANGE_CHECK_EN, defined:
  - addr_q ≥ DEPTH skips the wait states; the FSM goes straight to ACK on the capture edge.
  - No write is performed and rdata <= 0.
  - err=1 during that ack cycle; err=0 on every in-range ack.
- Not defined:
  - err is tied to 0.
  - Out-of-range writes are dropped and out-of-range reads return 0, but they take the normal WAIT_CYCLES latency.

## Structure
- Package mem_responder_pkg:
  - state encoding IDLE/WAIT/ACK;
  - ADDR_W=9 and DATA_W=32;
  - the wait-counter width constant (4).
- Sub-module mem_array: synchronous-write, synchronous-read DEPTH×32 RAM with ports clk, we, addr, d, q. The FSM and wait counter stay in mem_responder.

## Test plan
- Reset check: hold Reset_n=0, then release. Required: ack=0, busy=0, err=0, rdata=0, and no ack with req=0 for 20 cycles.
- WAIT_CYCLES=2, write 0xDEADBEEF at addr 0x010, then read 0x010. Required: each ack arrives exactly 3 edges after capture, and rdata=0xDEADBEEF.
- WAIT_CYCLES=0, back-to-back reads of addr 5 and 6 preloaded with 0x5/0x6, req held high continuously. Required: an ack every 2nd cycle, rdata 0x5 then 0x6.
- Assert Reset_n low during WAIT of a write of 0x12345678 to addr 7, where mem[7]=0xAAAA0000 beforehand. Required: mem[7] is still 0xAAAA0000 and no ack appears.
- DEPTH=256, macro defined, read addr 0x1F0. Required: ack one edge after capture, err=1, rdata=0. Without the macro: err=0, rdata=0, ack after WAIT_CYCLES+1 edges.
- Toggle req, we, addr and wdata during WAIT. Required: the completed access uses only the values captured at E0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the MAR/MDR memory responder.
package mem_responder_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Address is legal when it falls inside the populated part of the array.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return ({{(32-ADDR_W){1'b0}}, addr} < depth);
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// DEPTH x 32 RAM with synchronous write and synchronous (read-first) read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = addr[IDX_W-1:0];

  // Contents are deliberately left without reset so they survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= d;
    end
    q <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// req/ack memory responder with WAIT_CYCLES wait states in front of an internal RAM.
// Optional MEM_RESPONDER_RANGE_CHECK_EN: out-of-range requests ack immediately with err=1.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic             NO_WAIT   = (WAIT_CYCLES == 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              inRange_q, inRange_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              capture;
  logic              inRangeIn;
  logic              skipWait;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramD;
  logic [DATA_W-1:0] ramQ;
  logic [DATA_W-1:0] readSel;

  assign capture   = (state_q == IDLE) && req_i;
  assign inRangeIn = addr_in_range(addr_i, DEPTH);

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign skipWait = !inRangeIn;
`else
  assign skipWait = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = (NO_WAIT || skipWait) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge itself,
  // so the RAM is fed straight from the request inputs in IDLE.
  always_comb begin
    ack_o   = (state_q == ACK);
    busy_o  = (state_q != IDLE);
    ramAddr = (state_q == IDLE) ? addr_i : addr_q;
    ramD    = (state_q == IDLE) ? wdata_i : wdata_q;
    ramWe   = 1'b0;
    if (capture && NO_WAIT && we_i && inRangeIn) begin
      ramWe = 1'b1;
    end
    if ((state_q == WAIT) && (cnt_q == CNT_W'(1)) && we_q && inRange_q) begin
      ramWe = 1'b1;
    end
    readSel = inRange_q ? ramQ : '0;
    rdata_o = ((state_q == ACK) && !we_q) ? readSel : rdata_q;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    err_o   = (state_q == ACK) && !inRange_q;
`else
    err_o   = 1'b0;
`endif
  end

  always_comb begin
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    inRange_d = inRange_q;
    rdata_d   = rdata_q;
    if (capture) begin
      we_d      = we_i;
      addr_d    = addr_i;
      wdata_d   = wdata_i;
      inRange_d = inRangeIn;
      cnt_d     = skipWait ? '0 : WAIT_INIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Read data becomes sticky once the ack cycle is over.
    if ((state_q == ACK) && !we_q) begin
      rdata_d = readSel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      inRange_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      inRange_q <= inRange_d;
      rdata_q   <= rdata_d;
    end
  end

  mem_array #(
    .DEPTH(DEPTH)
  ) u_mem_array (
    .clk  (clk_i),
    .we   (ramWe),
    .addr (ramAddr),
    .d    (ramD),
    .q    (ramQ)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-wait-state, 256-word instance and a zero-wait, 512-word instance.
module tb_mem_responder;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam int A_WAIT = 2;
  localparam int A_LAT  = A_WAIT + 1;
  localparam int OOR_LAT = RANGE_EN ? 1 : A_LAT;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
  } txn_t;

  logic        clk, rst_n;
  logic        aReq, aWe, aAck, aBusy, aErr;
  logic [8:0]  aAddr;
  logic [31:0] aWdata, aRdata;
  logic        bReq, bWe, bAck, bBusy, bErr;
  logic [8:0]  bAddr;
  logic [31:0] bWdata, bRdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sbA[$];
  exp_t sbB[$];

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(A_WAIT)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .req_i(aReq), .we_i(aWe), .addr_i(aAddr),
    .wdata_i(aWdata), .rdata_o(aRdata), .ack_o(aAck), .busy_o(aBusy), .err_o(aErr)
  );

  mem_responder #(.DEPTH(512), .WAIT_CYCLES(0)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .req_i(bReq), .we_i(bWe), .addr_i(bAddr),
    .wdata_i(bWdata), .rdata_o(bRdata), .ack_o(bAck), .busy_o(bBusy), .err_o(bErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Waits for instance A to be idle, presents one request and returns #1 after the capture edge.
  task automatic issueA(input logic w, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    for (int i = 0; i < 50 && aBusy; i++) @(negedge clk);
    aReq = 1'b1; aWe = w; aAddr = a; aWdata = d;
    @(posedge clk); #1;
    aReq = 1'b0;
  endtask

  // Counts edges from the capture edge (inclusive) until ack is seen, bounded.
  task automatic waitAckA(output int lat, output bit seen);
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (aAck === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    int ackCount;
    rst_n = 1'b0;
    aReq = 0; aWe = 0; aAddr = '0; aWdata = '0;
    bReq = 0; bWe = 0; bAddr = '0; bWdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (aAck !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ack: got %b, expected 0", aAck); end
    checks++; if (aBusy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", aBusy); end
    checks++; if (aErr !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0", aErr); end
    checks++; if (aRdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h, expected 0", aRdata); end
    checks++;
    if ({bAck, bBusy, bErr} !== 3'b000 || bRdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_b: ack/busy/err=%b rdata=%h, expected 000 / 0", {bAck, bBusy, bErr}, bRdata);
    end
    ackCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (aAck === 1'b1 || bAck === 1'b1) ackCount++;
    end
    checks++; if (ackCount !== 0) begin errors++; $display("[TB] FAIL idle_no_ack: got %0d acks, expected 0", ackCount); end
  endtask

  task automatic test_write_read;
    txn_t t[2];
    exp_t e;
    int   lat;
    bit   seen;
    t[0] = '{1'b1, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0, A_LAT};
    t[1] = '{1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0, A_LAT};
    for (int i = 0; i < 2; i++) begin
      sbA.push_back('{t[i].expRdata, t[i].expErr, t[i].expLat});
      issueA(t[i].w, t[i].a, t[i].d);
      checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_capture[%0d]: got %b, expected 1", i, aBusy); end
      waitAckA(lat, seen);
      e = sbA.pop_front();
      checks++;
      if (!seen || lat != e.lat || aRdata !== e.rdata || aErr !== e.err) begin
        errors++;
        $display("[TB] FAIL write_read[%0d]: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                 i, seen, lat, aRdata, aErr, e.lat, e.rdata, e.err);
      end
      @(posedge clk); #1;
      checks++; if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_ack[%0d]: got %b, expected 0", i, aBusy); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ackSeq;
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bReq = 1'b1; bWe = 1'b1; bAddr = 9'(5 + i); bWdata = 32'(5 + i);
      @(posedge clk); #1;
      bReq = 1'b0;
      checks++; if (bAck !== 1'b1) begin errors++; $display("[TB] FAIL b_preload_ack[%0d]: got %b, expected 1", i, bAck); end
      @(posedge clk);
    end
    @(negedge clk);
    sbB.push_back('{32'h5, 1'b0, 1});
    sbB.push_back('{32'h6, 1'b0, 1});
    bReq = 1'b1; bWe = 1'b0; bAddr = 9'd5;
    ackSeq = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ackSeq[i] = bAck;
      if (bAck === 1'b1) begin
        checks++;
        if (sbB.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra_ack: ack at edge %0d with nothing outstanding", i);
        end else begin
          e = sbB.pop_front();
          if (bRdata !== e.rdata || bErr !== e.err) begin
            errors++; $display("[TB] FAIL b2b_rdata: edge %0d got rdata=%h err=%b, expected %h/%b", i, bRdata, bErr, e.rdata, e.err);
          end
        end
        bAddr = 9'd6;
        if (i >= 2) bReq = 1'b0;
      end else if (i == 1) begin
        checks++; if (bRdata !== 32'h5) begin errors++; $display("[TB] FAIL b2b_hold: got %h, expected 00000005", bRdata); end
      end
    end
    bReq = 1'b0;
    checks++; if (ackSeq !== 4'b0101) begin errors++; $display("[TB] FAIL b2b_ack_pattern: got %b, expected 0101", ackSeq); end
    checks++; if (sbB.size() != 0) begin errors++; $display("[TB] FAIL b2b_missing_ack: %0d outstanding, expected 0", sbB.size()); end
    sbB.delete();
  endtask

  task automatic test_reset_during_wait;
    exp_t e;
    int   lat, ackCount;
    bit   seen;
    sbA.push_back('{32'hDEADBEEF, 1'b0, A_LAT});
    issueA(1'b1, 9'd7, 32'hAAAA0000);
    waitAckA(lat, seen);
    e = sbA.pop_front();
    checks++;
    if (!seen || lat != e.lat || aRdata !== e.rdata) begin
      errors++; $display("[TB] FAIL preload7: seen=%0b lat=%0d rdata=%h, expected lat=%0d rdata=%h", seen, lat, aRdata, e.lat, e.rdata);
    end
    issueA(1'b1, 9'd7, 32'h12345678);
    ackCount = 0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (aAck === 1'b1) ackCount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (aAck === 1'b1) ackCount++;
    end
    checks++; if (ackCount !== 0) begin errors++; $display("[TB] FAIL abort_no_ack: got %0d acks, expected 0", ackCount); end
    checks++; if (aRdata !== 32'h0) begin errors++; $display("[TB] FAIL abort_rdata_reset: got %h, expected 0", aRdata); end
    sbA.push_back('{32'hAAAA0000, 1'b0, A_LAT});
    issueA(1'b0, 9'd7, 32'h0);
    waitAckA(lat, seen);
    e = sbA.pop_front();
    checks++;
    if (!seen || lat != e.lat || aRdata !== e.rdata || aErr !== e.err) begin
      errors++; $display("[TB] FAIL abort_mem7: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                         seen, lat, aRdata, aErr, e.lat, e.rdata, e.err);
    end
  endtask

  task automatic test_range;
    txn_t t[3];
    exp_t e;
    int   lat;
    bit   seen;
    t[0] = '{1'b1, 9'h110, 32'hFFFFFFFF, 32'hAAAA0000, RANGE_EN, OOR_LAT};
    t[1] = '{1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0,     A_LAT};
    t[2] = '{1'b0, 9'h1F0, 32'h0,        32'h0,        RANGE_EN, OOR_LAT};
    for (int i = 0; i < 3; i++) begin
      sbA.push_back('{t[i].expRdata, t[i].expErr, t[i].expLat});
      issueA(t[i].w, t[i].a, t[i].d);
      waitAckA(lat, seen);
      e = sbA.pop_front();
      checks++;
      if (!seen || lat != e.lat || aRdata !== e.rdata || aErr !== e.err) begin
        errors++;
        $display("[TB] FAIL range[%0d]: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                 i, seen, lat, aRdata, aErr, e.lat, e.rdata, e.err);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (aRdata !== 32'h0 || aErr !== 1'b0) begin
      errors++; $display("[TB] FAIL range_after_ack: rdata=%h err=%b, expected 0/0", aRdata, aErr);
    end
  endtask

  task automatic test_toggle;
    txn_t t[4];
    exp_t e;
    int   lat;
    bit   seen;
    sbA.push_back('{32'h0, 1'b0, A_LAT});
    issueA(1'b1, 9'h020, 32'h11111111);
    waitAckA(lat, seen);
    e = sbA.pop_front();
    checks++; if (!seen || lat != e.lat) begin errors++; $display("[TB] FAIL toggle_prep20: seen=%0b lat=%0d, expected lat=%0d", seen, lat, e.lat); end
    sbA.push_back('{32'h0, 1'b0, A_LAT});
    issueA(1'b1, 9'h021, 32'h22222222);
    waitAckA(lat, seen);
    e = sbA.pop_front();
    checks++; if (!seen || lat != e.lat) begin errors++; $display("[TB] FAIL toggle_prep21: seen=%0b lat=%0d, expected lat=%0d", seen, lat, e.lat); end

    sbA.push_back('{32'h0, 1'b0, A_LAT});
    @(negedge clk);
    for (int i = 0; i < 50 && aBusy; i++) @(negedge clk);
    aReq = 1'b1; aWe = 1'b1; aAddr = 9'h020; aWdata = 32'h0BADF00D;
    @(posedge clk); #1;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (aAck === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      aReq = 1'($urandom_range(0, 1)); aWe = 1'b0; aAddr = 9'h021; aWdata = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    aReq = 1'b0;
    e = sbA.pop_front();
    checks++;
    if (!seen || lat != e.lat || aRdata !== e.rdata || aErr !== e.err) begin
      errors++; $display("[TB] FAIL toggle_write: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                         seen, lat, aRdata, aErr, e.lat, e.rdata, e.err);
    end

    t[0] = '{1'b0, 9'h020, 32'h0, 32'h0BADF00D, 1'b0, A_LAT};
    t[1] = '{1'b0, 9'h021, 32'h0, 32'h22222222, 1'b0, A_LAT};
    for (int i = 0; i < 2; i++) begin
      sbA.push_back('{t[i].expRdata, t[i].expErr, t[i].expLat});
      issueA(t[i].w, t[i].a, t[i].d);
      waitAckA(lat, seen);
      e = sbA.pop_front();
      checks++;
      if (!seen || lat != e.lat || aRdata !== e.rdata || aErr !== e.err) begin
        errors++; $display("[TB] FAIL toggle_read[%0d]: seen=%0b lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                           i, seen, lat, aRdata, aErr, e.lat, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_during_wait();
    test_range();
    test_toggle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
